// File: rtl/call_scheduler_pkg.sv
// Shared definitions for the call scheduler: floor one-hot codes, floor
// indices, FSM state encoding and the index-to-one-hot helper.
// Floor 1 is index 0 and one-hot bit 4, floor 5 is index 4 and bit 0.
package call_scheduler_pkg;

  localparam int NUM_FLOORS = 5;

  localparam logic [4:0] P1 = 5'b10000;
  localparam logic [4:0] P2 = 5'b01000;
  localparam logic [4:0] P3 = 5'b00100;
  localparam logic [4:0] P4 = 5'b00010;
  localparam logic [4:0] P5 = 5'b00001;

  localparam logic [2:0] F1 = 3'd0;
  localparam logic [2:0] F2 = 3'd1;
  localparam logic [2:0] F3 = 3'd2;
  localparam logic [2:0] F4 = 3'd3;
  localparam logic [2:0] F5 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_TRAVEL = 3'd2,
    S_DWELL  = 3'd3,
    S_EMERG  = 3'd4
  } state_t;

  // Out-of-range indices map to "no floor" so a corrupted index never
  // produces a spurious command.
  function automatic logic [4:0] idx_to_onehot(input logic [2:0] idx);
    case (idx)
      F1:      return P1;
      F2:      return P2;
      F3:      return P3;
      F4:      return P4;
      F5:      return P5;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/call_picker.sv
// SCAN target picker (purely combinational).
// Ports:
//   pendientes  - pending-call mask (bit4 = floor1)
//   piso_actual - current floor index
//   dir_subida  - current scan direction, 1 = up
//   target      - chosen floor index
//   valid       - a target exists
//   dir_next    - direction to register when the target is issued
// A pending call on the current floor is neither above nor below; the
// scheduler serves it directly from IDLE.
module call_picker
  import call_scheduler_pkg::*;
(
  input  logic [4:0] pendientes,
  input  logic [2:0] piso_actual,
  input  logic       dir_subida,
  output logic [2:0] target,
  output logic       valid,
  output logic       dir_next
);

  logic [2:0] above_s;
  logic [2:0] below_s;
  logic       has_above_s;
  logic       has_below_s;

  // Nearest pending floor above (scan downward) and below (scan upward).
  always_comb begin
    above_s     = 3'd0;
    below_s     = 3'd0;
    has_above_s = 1'b0;
    has_below_s = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      above_s     = (pendientes[4 - i] && (3'(i) > piso_actual)) ? 3'(i) : above_s;
      has_above_s = has_above_s | (pendientes[4 - i] && (3'(i) > piso_actual));
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      below_s     = (pendientes[4 - i] && (3'(i) < piso_actual)) ? 3'(i) : below_s;
      has_below_s = has_below_s | (pendientes[4 - i] && (3'(i) < piso_actual));
    end
  end

  // Keep the current direction while calls remain ahead, else reverse.
  always_comb begin
    target   = piso_actual;
    valid    = 1'b0;
    dir_next = dir_subida;
    if (dir_subida) begin
      if (has_above_s) begin
        target = above_s; valid = 1'b1; dir_next = 1'b1;
      end else if (has_below_s) begin
        target = below_s; valid = 1'b1; dir_next = 1'b0;
      end else begin
        valid = 1'b0;
      end
    end else begin
      if (has_below_s) begin
        target = below_s; valid = 1'b1; dir_next = 1'b0;
      end else if (has_above_s) begin
        target = above_s; valid = 1'b1; dir_next = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// Call-request scheduler in front of the freight-elevator FSM.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   btn        - floor call buttons (bit4 = floor1 ... bit0 = floor5)
//   fc         - limit switches, same bit order as btn
//   emergencia - emergency, active high
//   puerta     - door open, active high
//   selector   - registered one-hot floor command, 0 = no command
//   pendientes - registered pending-call mask
//   dir_subida - registered scan direction, 1 = up
//   ocupado    - registered, high whenever the FSM is not IDLE
module call_scheduler
  import call_scheduler_pkg::*;
#(
  parameter int DWELL_CYCLES  = 50000000,
  parameter int ISSUE_TIMEOUT = 1024,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [4:0] fc,
  input  logic       emergencia,
  input  logic       puerta,
  output logic [4:0] selector,
  output logic [4:0] pendientes,
  output logic       dir_subida,
  output logic       ocupado
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(ISSUE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r, state_s;
  logic [2:0]       piso_r, piso_s;
  logic [2:0]       destino_r, destino_s;
  logic             dir_r, dir_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [4:0]       pend_r, pend_s, clr_s;
  logic [4:0]       sel_r, sel_s;
  logic             ocup_r;
  logic [2:0]       target_s;
  logic             valid_s;
  logic             dir_next_s;

  call_picker u_picker (
    .pendientes  (pend_r),
    .piso_actual (piso_r),
    .dir_subida  (dir_r),
    .target      (target_s),
    .valid       (valid_s),
    .dir_next    (dir_next_s)
  );

  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      piso_r    <= F1;
      destino_r <= F1;
      dir_r     <= 1'b1;
      cnt_r     <= {CNT_W{1'b0}};
      pend_r    <= 5'b00000;
      sel_r     <= 5'b00000;
      ocup_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      piso_r    <= piso_s;
      destino_r <= destino_s;
      dir_r     <= dir_s;
      cnt_r     <= cnt_s;
      pend_r    <= pend_s;
      sel_r     <= sel_s;
      ocup_r    <= (state_s != S_IDLE);
    end
  end

  // Next-state, request latch and floor tracking.
  always_comb begin
    state_s   = state_r;
    destino_s = destino_r;
    dir_s     = dir_r;
    cnt_s     = cnt_r;
    sel_s     = sel_r;
    clr_s     = 5'b00000;
    // Only an unambiguous single limit switch moves the floor estimate.
    case (fc)
      P1:      piso_s = F1;
      P2:      piso_s = F2;
      P3:      piso_s = F3;
      P4:      piso_s = F4;
      P5:      piso_s = F5;
      default: piso_s = piso_r;
    endcase

    if (emergencia) begin
      state_s = S_EMERG;
      sel_s   = 5'b00000;
      cnt_s   = {CNT_W{1'b0}};
      clr_s   = 5'b11111;
    end else begin
      case (state_r)
        S_IDLE: begin
          if ((pend_r & idx_to_onehot(piso_r)) != 5'b00000) begin
            clr_s   = idx_to_onehot(piso_r);
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_DWELL;
          end else if (valid_s && !puerta) begin
            destino_s = target_s;
            dir_s     = dir_next_s;
            sel_s     = idx_to_onehot(target_s);
            cnt_s     = {CNT_W{1'b0}};
            state_s   = S_ISSUE;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_ISSUE: begin
          if ((fc & idx_to_onehot(piso_r)) == 5'b00000) begin
            sel_s   = 5'b00000;
            state_s = S_TRAVEL;
          end else if (cnt_r == ISSUE_LAST) begin
            // Abandon the command; the call stays pending for a retry.
            sel_s   = 5'b00000;
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_IDLE;
          end else if (!puerta) begin
            cnt_s = cnt_inc_s;
          end else begin
            cnt_s = cnt_r;
          end
        end
        S_TRAVEL: begin
          sel_s = 5'b00000;
          if ((fc & idx_to_onehot(destino_r)) != 5'b00000) begin
            clr_s   = idx_to_onehot(destino_r);
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_DWELL;
          end else begin
            state_s = S_TRAVEL;
          end
        end
        S_DWELL: begin
          if (puerta) begin
            cnt_s = {CNT_W{1'b0}};
          end else if (cnt_r == DWELL_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_IDLE;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        S_EMERG: begin
          sel_s = 5'b00000;
          clr_s = 5'b11111;
          if (fc[4]) begin
            piso_s  = F1;
            dir_s   = 1'b1;
            state_s = S_IDLE;
          end else begin
            state_s = S_EMERG;
          end
        end
        default: begin
          sel_s   = 5'b00000;
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_IDLE;
        end
      endcase
    end

    // Clear wins over a simultaneous button press; buttons are ignored in EMERG.
    if (emergencia || (state_r == S_EMERG)) begin
      pend_s = 5'b00000;
    end else begin
      pend_s = (pend_r | btn) & ~clr_s;
    end
  end

  assign selector   = sel_r;
  assign pendientes = pend_r;
  assign dir_subida = dir_r;
  assign ocupado    = ocup_r;

endmodule

// File: tb/tb_call_scheduler.sv
module tb_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [4:0] fc;
  logic       emergencia;
  logic       puerta;
  logic [4:0] selector;
  logic [4:0] pendientes;
  logic       dir_subida;
  logic       ocupado;

  int nchk  = 0;
  int nfail = 0;
  logic [4:0] exp_q[$];

  call_scheduler #(.DWELL_CYCLES(4), .ISSUE_TIMEOUT(8), .CNT_W(26)) dut (
    .clk(clk), .reset(reset), .btn(btn), .fc(fc), .emergencia(emergencia),
    .puerta(puerta), .selector(selector), .pendientes(pendientes),
    .dir_subida(dir_subida), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    tick();
    btn = 5'b00000;
  endtask

  // Wait (bounded) for the DUT to issue a command.
  task automatic wait_sel(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (selector != 5'b00000) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Act as the car: wait for a command, depart, arrive, wait for dwell to end.
  task automatic serve(output logic [4:0] s, output logic d, output bit ok);
    bit got;
    s = 5'b00000; d = 1'b0;
    wait_sel(got);
    ok = 1'b0;
    if (got) begin
      s = selector; d = dir_subida;
      fc = 5'b00000; tick();
      fc = s;        tick();
      for (int i = 0; i < 20; i++) begin
        if (!ocupado) begin ok = 1'b1; break; end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 5'b0; fc = 5'b10000; emergencia = 1'b0; puerta = 1'b0;
    #1 reset = 1'b0;
    tick(); tick();
    nchk++; if (selector !== 5'b00000) begin nfail++; $display("FAIL reset_sel got %b want 00000", selector); end
    nchk++; if (pendientes !== 5'b00000) begin nfail++; $display("FAIL reset_pend got %b want 00000", pendientes); end
    nchk++; if (dir_subida !== 1'b1) begin nfail++; $display("FAIL reset_dir got %b want 1", dir_subida); end
    nchk++; if (ocupado !== 1'b0) begin nfail++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    logic [4:0] e;
    exp_q.push_back(5'b01000);
    press(5'b01000);
    wait_sel(ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || selector !== e) begin nfail++; $display("FAIL basic_issue got %b want %b", selector, e); end
    nchk++; if (pendientes !== 5'b01000) begin nfail++; $display("FAIL basic_pend got %b want 01000", pendientes); end
    fc = 5'b00000; tick();
    nchk++; if (selector !== 5'b00000 || ocupado !== 1'b1) begin nfail++; $display("FAIL basic_travel got sel=%b ocu=%b want 00000/1", selector, ocupado); end
    fc = 5'b01000; tick();
    nchk++; if (pendientes !== 5'b00000) begin nfail++; $display("FAIL basic_arrive got %b want 00000", pendientes); end
    tick(); tick(); tick();
    nchk++; if (ocupado !== 1'b1) begin nfail++; $display("FAIL basic_dwell got %b want 1", ocupado); end
    tick();
    nchk++; if (ocupado !== 1'b0) begin nfail++; $display("FAIL basic_idle got %b want 0", ocupado); end
  endtask

  task automatic test_scan();
    bit ok;
    logic [4:0] s, e;
    logic d;
    exp_q.push_back(5'b00100);
    press(5'b00100);
    serve(s, d, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || s !== e) begin nfail++; $display("FAIL scan_to_f3 got %b want %b", s, e); end
    exp_q.push_back(5'b00010); exp_q.push_back(5'b00001); exp_q.push_back(5'b10000);
    press(5'b10011);
    for (int k = 0; k < 3; k++) begin
      serve(s, d, ok);
      e = exp_q.pop_front();
      nchk++; if (!ok || s !== e) begin nfail++; $display("FAIL scan_order%0d got %b want %b", k, s, e); end
      nchk++; if (d !== (k < 2)) begin nfail++; $display("FAIL scan_dir%0d got %b want %b", k, d, (k < 2)); end
    end
  endtask

  task automatic test_door();
    bit ok;
    logic [4:0] s, e;
    logic d;
    puerta = 1'b1;
    exp_q.push_back(5'b00001);
    press(5'b00001);
    for (int k = 0; k < 3; k++) begin
      nchk++; if (selector !== 5'b00000) begin nfail++; $display("FAIL door_hold%0d got %b want 00000", k, selector); end
      tick();
    end
    nchk++; if (pendientes !== 5'b00001) begin nfail++; $display("FAIL door_pend got %b want 00001", pendientes); end
    puerta = 1'b0; tick();
    e = exp_q.pop_front();
    nchk++; if (selector !== e) begin nfail++; $display("FAIL door_release got %b want %b", selector, e); end
    serve(s, d, ok);
    nchk++; if (!ok || s !== e) begin nfail++; $display("FAIL door_trip got %b want %b", s, e); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [4:0] s, e;
    logic d;
    exp_q.push_back(5'b00100); exp_q.push_back(5'b00100);
    press(5'b00100);
    wait_sel(ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || selector !== e) begin nfail++; $display("FAIL to_issue got %b want %b", selector, e); end
    repeat (7) tick();
    nchk++; if (selector !== 5'b00100) begin nfail++; $display("FAIL to_held got %b want 00100", selector); end
    tick();
    nchk++; if (selector !== 5'b00000 || ocupado !== 1'b0) begin nfail++; $display("FAIL to_abandon got sel=%b ocu=%b want 00000/0", selector, ocupado); end
    nchk++; if (pendientes !== 5'b00100) begin nfail++; $display("FAIL to_pend got %b want 00100", pendientes); end
    tick();
    e = exp_q.pop_front();
    nchk++; if (selector !== e) begin nfail++; $display("FAIL to_reissue got %b want %b", selector, e); end
    serve(s, d, ok);
    nchk++; if (!ok || d !== 1'b0) begin nfail++; $display("FAIL to_trip got ok=%b dir=%b want 1/0", ok, d); end
  endtask

  task automatic test_emerg();
    bit ok;
    logic [4:0] e;
    exp_q.push_back(5'b10000);
    press(5'b10000);
    wait_sel(ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || selector !== e) begin nfail++; $display("FAIL em_issue got %b want %b", selector, e); end
    fc = 5'b00000; tick();
    press(5'b00011);
    nchk++; if (pendientes !== 5'b10011) begin nfail++; $display("FAIL em_prepend got %b want 10011", pendientes); end
    emergencia = 1'b1; tick();
    nchk++; if (pendientes !== 5'b00000 || selector !== 5'b00000) begin nfail++; $display("FAIL em_flush got pend=%b sel=%b want 0/0", pendientes, selector); end
    press(5'b01111);
    nchk++; if (pendientes !== 5'b00000) begin nfail++; $display("FAIL em_btn_ignored got %b want 00000", pendientes); end
    emergencia = 1'b0; tick();
    nchk++; if (ocupado !== 1'b1) begin nfail++; $display("FAIL em_stay got %b want 1", ocupado); end
    fc = 5'b10000; tick();
    nchk++; if (ocupado !== 1'b0 || dir_subida !== 1'b1) begin nfail++; $display("FAIL em_exit got ocu=%b dir=%b want 0/1", ocupado, dir_subida); end
  endtask

  task automatic test_same_floor();
    bit ok;
    logic [4:0] s, e;
    logic d;
    int seen;
    exp_q.push_back(5'b01000);
    press(5'b01000);
    serve(s, d, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || s !== e) begin nfail++; $display("FAIL sf_setup got %b want %b", s, e); end
    seen = 0;
    press(5'b01000);
    if (selector != 5'b00000) seen++;
    tick();
    nchk++; if (pendientes !== 5'b00000 || ocupado !== 1'b1) begin nfail++; $display("FAIL sf_clear got pend=%b ocu=%b want 00000/1", pendientes, ocupado); end
    for (int k = 0; k < 6; k++) begin
      if (selector != 5'b00000) seen++;
      tick();
    end
    nchk++; if (seen != 0 || ocupado !== 1'b0) begin nfail++; $display("FAIL sf_no_sel got seen=%0d ocu=%b want 0/0", seen, ocupado); end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [4:0] e;
    exp_q.push_back(5'b00001);
    press(5'b00001);
    wait_sel(ok);
    e = exp_q.pop_front();
    nchk++; if (!ok || selector !== e) begin nfail++; $display("FAIL ar_issue got %b want %b", selector, e); end
    #2 reset = 1'b0;
    #1;
    nchk++; if (selector !== 5'b00000 || pendientes !== 5'b00000) begin nfail++; $display("FAIL ar_clear got sel=%b pend=%b want 0/0", selector, pendientes); end
    nchk++; if (ocupado !== 1'b0 || dir_subida !== 1'b1) begin nfail++; $display("FAIL ar_state got ocu=%b dir=%b want 0/1", ocupado, dir_subida); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scan();
    test_door();
    test_timeout();
    test_emerg();
    test_same_floor();
    test_async_reset();
    nchk++; if (exp_q.size() != 0) begin nfail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
